// File: rtl/oc8051_fetch_pkg.sv
// Shared types and constants for the oc8051 code-ROM fetch unit.
package oc8051_fetch_pkg;

  localparam int ROM_DEPTH_DEF = 10000;
  localparam int QDEPTH_DEF    = 8;
  localparam int FETCH_BYTES   = 4;

  // Byte address into code space.
  typedef logic [15:0] code_addr_t;

  // Extract byte lane 'lane' of a little-endian 32-bit ROM word.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/oc8051_byte_queue.sv
// Circular byte buffer: accepts 4 bytes per push, releases 0-3 bytes per pop,
// and exposes the 3 oldest bytes (zero beyond the fill level) plus the count.
module oc8051_byte_queue
  import oc8051_fetch_pkg::*;
#(
  parameter  int QDEPTH = QDEPTH_DEF,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [31:0]   push_data_i,
  input  logic [1:0]    pop_i,
  output logic [23:0]   head_o,
  output logic [CW-1:0] cnt_o
);

  logic [7:0]    mem_q [QDEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;

  // Pointer and fill-level update; pop is applied before push, flush wins.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(FETCH_BYTES);
      cnt_q <= cnt_q - CW'(pop_i) + (push_i ? CW'(FETCH_BYTES) : CW'(0));
    end
  end

  // Byte storage written four lanes at a time behind the surviving bytes.
  // NOTE: the array has no reset; entries past the fill level are never shown.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      for (int k = 0; k < FETCH_BYTES; k++) begin
        mem_q[wr_ptr_q + PW'(k)] <= byte_lane(push_data_i, 2'(k));
      end
    end
  end

  // Head window: oldest 3 bytes, zeroed where the queue holds fewer.
  // NOTE: head_o gets a default first so no path can infer a latch.
  always_comb begin
    head_o = '0;
    for (int k = 0; k < 3; k++) begin
      if (cnt_q > CW'(k)) head_o[8*k +: 8] = mem_q[rd_ptr_q + PW'(k)];
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// oc8051 fetch unit for a combinational code ROM. Fetches aligned-free 4-byte
// words into a byte queue and presents the next 3 instruction bytes.
// Optional macro OC8051_CXFETCH_BOUND_EN enables the ROM range check that
// drives the sticky fetch_err flag; without it fetch_err is always 0.
module oc8051_cxrom_fetch
  import oc8051_fetch_pkg::*;
#(
  parameter int QDEPTH    = QDEPTH_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  code_addr_t  redirect_pc,
  input  logic [1:0]  pop_cnt,
  output logic [23:0] ib_data,
  output logic [3:0]  ib_cnt,
  output code_addr_t  ib_pc,
  output code_addr_t  cxrom_addr,
  input  logic [31:0] cxrom_data_in,
  output logic        pop_err,
  output logic        fetch_err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  // ib_cnt is 4 bits wide, so the queue cannot exceed 8 bytes here.
  if (QDEPTH != 8) begin : g_bad_qdepth
    $error("oc8051_cxrom_fetch: QDEPTH must be 8 to fit the 4-bit ib_cnt port");
  end
  if (ROM_DEPTH < FETCH_BYTES || ROM_DEPTH > 65536) begin : g_bad_rom_depth
    $error("oc8051_cxrom_fetch: ROM_DEPTH must lie in 4..65536");
  end

  code_addr_t    fetch_pc_q;
  code_addr_t    ib_pc_q;
  logic          pop_err_q;
  logic          fetch_err_q;
  logic [CW-1:0] q_cnt;
  logic          pop_ok;
  logic [1:0]    pop_eff;
  logic [CW-1:0] remain;
  logic          fault;
  logic          push;

  // Pop legality, range fault and the push decision for this cycle.
  always_comb begin
    pop_ok  = CW'(pop_cnt) <= q_cnt;
    pop_eff = pop_ok ? pop_cnt : 2'd0;
    remain  = q_cnt - CW'(pop_eff);
`ifdef OC8051_CXFETCH_BOUND_EN
    // A word whose last byte lies past the ROM or wraps 64K holds X bytes.
    fault = (int'(fetch_pc_q) > ROM_DEPTH - FETCH_BYTES) || (fetch_pc_q > 16'hFFFC);
`else
    fault = 1'b0;
`endif
    push = !redirect && !fault && (int'(remain) <= QDEPTH - FETCH_BYTES);
  end

  // Fetch/instruction pointers and status flags; redirect overrides pop and push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= '0;
      ib_pc_q     <= '0;
      pop_err_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      pop_err_q <= !pop_ok;
      if (redirect) begin
        fetch_pc_q  <= redirect_pc;
        ib_pc_q     <= redirect_pc;
        fetch_err_q <= 1'b0;
      end else begin
        ib_pc_q <= ib_pc_q + code_addr_t'(pop_eff);
        if (push)  fetch_pc_q  <= fetch_pc_q + code_addr_t'(FETCH_BYTES);
        if (fault) fetch_err_q <= 1'b1;
      end
    end
  end

  oc8051_byte_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (cxrom_data_in),
    .pop_i       (pop_eff),
    .head_o      (ib_data),
    .cnt_o       (q_cnt)
  );

  assign ib_cnt     = 4'(q_cnt);
  assign ib_pc      = ib_pc_q;
  assign cxrom_addr = fetch_pc_q;
  assign pop_err    = pop_err_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Self-checking bench for oc8051_cxrom_fetch: a byte-level reference queue
// produces the expected outputs of every cycle into a scoreboard that a
// separate monitor drains; directed checks use hand-computed constants.
`timescale 1ns/1ps
module tb_oc8051_cxrom_fetch;

  localparam int QD = 8;
  localparam int RD = 10000;
`ifdef OC8051_CXFETCH_BOUND_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [1:0]  pop_cnt = '0;
  logic [23:0] ib_data;
  logic [3:0]  ib_cnt;
  logic [15:0] ib_pc;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        pop_err;
  logic        fetch_err;

  always #5 clk = ~clk;

  oc8051_cxrom_fetch #(.QDEPTH(QD), .ROM_DEPTH(RD)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .pop_cnt       (pop_cnt),
    .ib_data       (ib_data),
    .ib_cnt        (ib_cnt),
    .ib_pc         (ib_pc),
    .cxrom_addr    (cxrom_addr),
    .cxrom_data_in (cxrom_data_in),
    .pop_err       (pop_err),
    .fetch_err     (fetch_err)
  );

  // ROM image: bytes 0..7 are 01..08; the high address byte scrambles the rest.
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return (a[7:0] + 8'd1) ^ a[15:8];
  endfunction

  assign cxrom_data_in = {rom_byte(cxrom_addr + 16'd3), rom_byte(cxrom_addr + 16'd2),
                          rom_byte(cxrom_addr + 16'd1), rom_byte(cxrom_addr)};

  typedef struct packed {
    logic [3:0]  cnt;
    logic [15:0] pc;
    logic [23:0] data;
    logic [15:0] addr;
    logic        perr;
    logic        ferr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;

  // Reference state.
  logic [7:0]  m_q[$];
  logic [15:0] m_ibpc = '0;
  logic [15:0] m_fpc = '0;
  logic        m_err = 1'b0;
  logic        m_perr = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ibpc = '0;
    m_fpc  = '0;
    m_err  = 1'b0;
    m_perr = 1'b0;
  endtask

  // One clock: drive inputs at a negedge, advance the model at the posedge,
  // queue the expected outputs, and return at the following negedge.
  task automatic step(input logic rd, input logic [15:0] rpc, input logic [1:0] pop);
    int   pe;
    bit   fault;
    bit   push;
    exp_t e;
    redirect    = rd;
    redirect_pc = rpc;
    pop_cnt     = pop;
    @(posedge clk);
    m_perr = int'(pop) > m_q.size();
    pe     = m_perr ? 0 : int'(pop);
    if (rd) begin
      m_q.delete();
      m_ibpc = rpc;
      m_fpc  = rpc;
      m_err  = 1'b0;
    end else begin
      fault = BOUND && ((int'(m_fpc) > RD - 4) || (m_fpc > 16'hFFFC));
      push  = !fault && (m_q.size() - pe <= QD - 4);
      repeat (pe) void'(m_q.pop_front());
      m_ibpc = m_ibpc + 16'(pe);
      if (push) begin
        for (int k = 0; k < 4; k++) m_q.push_back(rom_byte(m_fpc + 16'(k)));
        m_fpc = m_fpc + 16'd4;
      end
      if (fault) m_err = 1'b1;
    end
    e.cnt  = 4'(m_q.size());
    e.pc   = m_ibpc;
    e.data = '0;
    for (int k = 0; k < 3; k++) if (k < m_q.size()) e.data[8*k +: 8] = m_q[k];
    e.addr = m_fpc;
    e.perr = m_perr;
    e.ferr = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs are presented every cycle, compare 1ns after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_ib_cnt",     ib_cnt,     mon_e.cnt);
      check("sb_ib_pc",      ib_pc,      mon_e.pc);
      check("sb_ib_data",    ib_data,    mon_e.data);
      check("sb_cxrom_addr", cxrom_addr, mon_e.addr);
      check("sb_pop_err",    pop_err,    mon_e.perr);
      check("sb_fetch_err",  fetch_err,  mon_e.ferr);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ib_cnt",     ib_cnt,     4'd0);
    check("rst_ib_pc",      ib_pc,      16'd0);
    check("rst_ib_data",    ib_data,    24'd0);
    check("rst_cxrom_addr", cxrom_addr, 16'd0);
    check("rst_pop_err",    pop_err,    1'b0);
    check("rst_fetch_err",  fetch_err,  1'b0);
    rst = 1'b1;

    // 1: fill from address 0 with no pops.
    check("t1_addr0", cxrom_addr, 16'h0000);
    step(1'b0, 16'h0, 2'd0);
    check("t1_cnt4",  ib_cnt,  4'd4);
    check("t1_data",  ib_data, 24'h030201);
    step(1'b0, 16'h0, 2'd0);
    check("t1_cnt8",  ib_cnt,  4'd8);
    step(1'b0, 16'h0, 2'd0);
    check("t1_hold_cnt",  ib_cnt,     4'd8);
    check("t1_hold_addr", cxrom_addr, 16'h0008);

    // 2: pops against a full queue.
    step(1'b0, 16'h0, 2'd3);
    check("t2_cnt5",  ib_cnt,  4'd5);
    check("t2_pc3",   ib_pc,   16'h0003);
    check("t2_data",  ib_data, 24'h060504);
    step(1'b0, 16'h0, 2'd1);
    check("t2_cnt8",  ib_cnt,  4'd8);
    check("t2_pc4",   ib_pc,   16'h0004);
    check("t2_data2", ib_data, 24'h070605);

    // 3: redirect overrides a concurrent pop.
    step(1'b1, 16'h0123, 2'd2);
    check("t3_cnt0", ib_cnt,     4'd0);
    check("t3_pc",   ib_pc,      16'h0123);
    check("t3_addr", cxrom_addr, 16'h0123);
    step(1'b0, 16'h0, 2'd0);
    check("t3_cnt4", ib_cnt,  4'd4);
    check("t3_data", ib_data, 24'h272425);

    // 4: over-pop is flagged and ignored, then a random pop stream.
    step(1'b1, 16'h0200, 2'd0);
    step(1'b0, 16'h0, 2'd3);
    check("t4_pop_err",  pop_err, 1'b1);
    check("t4_pc_kept",  ib_pc,   16'h0200);
    step(1'b0, 16'h0, 2'd0);
    check("t4_pop_err_clear", pop_err, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(19) == 0) step(1'b1, 16'($urandom), 2'($urandom_range(3)));
      else                         step(1'b0, 16'h0,         2'($urandom_range(3)));
    end

`ifndef OC8051_CXFETCH_BOUND_EN
    // 5: fetch across the top of code space.
    step(1'b1, 16'hFFFE, 2'd0);
    check("t5_addr_fffe", cxrom_addr, 16'hFFFE);
    step(1'b0, 16'h0, 2'd0);
    check("t5_addr_0002", cxrom_addr, 16'h0002);
    check("t5_data",      ib_data,    24'h01FF00);
    step(1'b0, 16'h0, 2'd2);
    check("t5_pc_wrap",   ib_pc,      16'h0000);
    check("t5_data2",     ib_data,    24'h030201);
    check("t5_cnt6",      ib_cnt,     4'd6);
`else
    // 6: range fault near the end of ROM, cleared by redirect.
    step(1'b1, 16'd9998, 2'd0);
    check("t6_addr",      cxrom_addr, 16'd9998);
    step(1'b0, 16'h0, 2'd0);
    check("t6_ferr_set",  fetch_err,  1'b1);
    check("t6_no_push",   ib_cnt,     4'd0);
    step(1'b0, 16'h0, 2'd0);
    check("t6_ferr_hold", fetch_err,  1'b1);
    check("t6_stall",     cxrom_addr, 16'd9998);
    step(1'b1, 16'h0000, 2'd0);
    check("t6_ferr_clr",  fetch_err,  1'b0);
    step(1'b0, 16'h0, 2'd0);
    check("t6_resume",    ib_data,    24'h030201);
`endif

    // Reset in the middle of traffic discards the queue.
    step(1'b0, 16'h0, 2'd1);
    step(1'b0, 16'h0, 2'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_cnt",  ib_cnt,     4'd0);
    check("mid_rst_pc",   ib_pc,      16'h0000);
    check("mid_rst_addr", cxrom_addr, 16'h0000);
    model_reset();
    redirect = 1'b0;
    pop_cnt  = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 16'h0, 2'd0);
    check("post_rst_cnt",  ib_cnt,  4'd4);
    check("post_rst_data", ib_data, 24'h030201);
    step(1'b0, 16'h0, 2'd3);
    step(1'b0, 16'h0, 2'd2);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
